// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, buffers fetched words with their PC in a FIFO.
// Optional J-target predecode is enabled by defining FETCH_JUMP_PREDECODE_EN.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned IMEM_AW  = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    output logic [IMEM_AW-1:0]      o_imem_addr,
    input  logic [31:0]             i_imem_rd,
    input  logic                    i_redirect,
    input  logic [31:0]             i_redirect_pc,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [31:0]             o_out_instr,
    output logic [31:0]             o_out_pc,
    output logic [31:0]             o_out_pcplus4,
    output logic                    o_out_jtaken,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      r_fetch_pc;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_instr_q [DEPTH];
    logic [31:0]      r_pc_q    [DEPTH];

    logic        w_push;
    logic        w_pop;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_unused;

    // Low redirect PC bits are forced to zero, so they are never observed.
    assign w_unused = ^i_redirect_pc[1:0];

    assign o_out_valid = (r_count != '0);
    assign w_pop       = o_out_valid & i_out_ready & ~i_redirect;
    assign w_push      = ~i_redirect & ((r_count < CNT_W'(DEPTH)) | w_pop);
    assign w_pc_plus4  = r_fetch_pc + 32'd4;
    assign o_imem_addr = r_fetch_pc[IMEM_AW+1:2];

`ifdef FETCH_JUMP_PREDECODE_EN
    logic w_is_j;
    logic r_jt_q [DEPTH];

    assign w_is_j    = (i_imem_rd[31:26] == 6'b000010);
    assign w_next_pc = w_is_j ? {w_pc_plus4[31:28], i_imem_rd[25:0], 2'b00} : w_pc_plus4;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_jt_q[r_tail] <= w_is_j;
        end
    end

    // Storage is not reset, so qualify with valid to keep jtaken low after reset.
    assign o_out_jtaken = o_out_valid & r_jt_q[r_head];
`else
    assign w_next_pc    = w_pc_plus4;
    assign o_out_jtaken = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (i_redirect) begin
            r_fetch_pc <= {i_redirect_pc[31:2], 2'b00};
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_tail     <= r_tail + PTR_W'(1);
                r_fetch_pc <= w_next_pc;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_instr_q[r_tail] <= i_imem_rd;
            r_pc_q[r_tail]    <= r_fetch_pc;
        end
    end

    assign o_out_instr   = r_instr_q[r_head];
    assign o_out_pc      = r_pc_q[r_head];
    assign o_out_pcplus4 = r_pc_q[r_head] + 32'd4;
    assign o_count       = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue; imem word k holds 32'h2008_0000 + k.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rd;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;
    logic        out_jtaken;
    logic [2:0]  count;

    logic [31:0] mem [64];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_rd = mem[imem_addr];

    fetch_queue #(.DEPTH(4), .IMEM_AW(6), .RESET_PC(32'h0000_0000)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .o_imem_addr   (imem_addr),
        .i_imem_rd     (imem_rd),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_instr   (out_instr),
        .o_out_pc      (out_pc),
        .o_out_pcplus4 (out_pcplus4),
        .o_out_jtaken  (out_jtaken),
        .o_count       (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset and release it on the falling edge; the next rising edge pushes RESET_PC.
    task automatic do_reset(input logic rdy);
        tick();
        reset     = 1'b1;
        redirect  = 1'b0;
        out_ready = rdy;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid);
        end
        checks++;
        if (count !== 3'd0) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", count);
        end
        checks++;
        if (imem_addr !== 6'd0) begin
            failures++; $display("FAIL reset_imem_addr got=%0d exp=0", imem_addr);
        end
        checks++;
        if (out_jtaken !== 1'b0) begin
            failures++; $display("FAIL reset_jtaken got=%0b exp=0", out_jtaken);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || count !== 3'd1) begin
                failures++;
                $display("FAIL stream_pc k=%0d got v=%0b pc=%h cnt=%0d exp v=1 pc=%h cnt=1",
                         k, out_valid, out_pc, count, 32'(4 * k));
            end
            checks++;
            if (out_instr !== 32'h2008_0000 + 32'(k)) begin
                failures++;
                $display("FAIL stream_instr k=%0d got=%h exp=%h", k, out_instr,
                         32'h2008_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (count !== 3'd4 || imem_addr !== 6'd4 || out_pc !== 32'h0) begin
            failures++;
            $display("FAIL bp_full got cnt=%0d addr=%0d pc=%h exp cnt=4 addr=4 pc=0",
                     count, imem_addr, out_pc);
        end
        out_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            checks++;
            if (out_pc !== 32'(4 * j) || count !== 3'd4) begin
                failures++;
                $display("FAIL bp_drain j=%0d got pc=%h cnt=%0d exp pc=%h cnt=4",
                         j, out_pc, count, 32'(4 * j));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0023;
        out_ready   = 1'b1;
        tick();
        redirect = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 6'd8) begin
            failures++;
            $display("FAIL redir_flush got cnt=%0d v=%0b addr=%0d exp cnt=0 v=0 addr=8",
                     count, out_valid, imem_addr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_pcplus4 !== 32'h24
            || out_instr !== 32'h2008_0008 || count !== 3'd1) begin
            failures++;
            $display("FAIL redir_entry got v=%0b pc=%h pc4=%h ins=%h cnt=%0d exp 1 20 24 20080008 1",
                     out_valid, out_pc, out_pcplus4, out_instr, count);
        end
    endtask

    task automatic test_jump();
        logic [31:0] exp_pc [5];
        logic        exp_jt [5];
`ifdef FETCH_JUMP_PREDECODE_EN
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44};
        exp_jt = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        exp_jt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        mem[2] = 32'h0800_0010;
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (out_pc !== exp_pc[k] || out_jtaken !== exp_jt[k]) begin
                failures++;
                $display("FAIL jump k=%0d got pc=%h jt=%0b exp pc=%h jt=%0b",
                         k, out_pc, out_jtaken, exp_pc[k], exp_jt[k]);
            end
        end
        mem[2] = 32'h2008_0002;
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (count !== 3'd3) begin
            failures++; $display("FAIL areset_pre got cnt=%0d exp=3", count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL areset_now got cnt=%0d v=%0b exp cnt=0 v=0", count, out_valid);
        end
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            failures++;
            $display("FAIL areset_restart got v=%0b pc=%h exp v=1 pc=0", out_valid, out_pc);
        end
        tick();
        checks++;
        if (out_pc !== 32'h4) begin
            failures++; $display("FAIL areset_next got pc=%h exp=4", out_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        checks++;
        if (out_pc !== 32'hFFFF_FFFC || out_pcplus4 !== 32'h0 || out_instr !== 32'h2008_003F) begin
            failures++;
            $display("FAIL wrap_entry got pc=%h pc4=%h ins=%h exp fffffffc 0 2008003f",
                     out_pc, out_pcplus4, out_instr);
        end
        tick();
        checks++;
        if (out_pc !== 32'h0 || out_instr !== 32'h2008_0000) begin
            failures++;
            $display("FAIL wrap_next got pc=%h ins=%h exp pc=0 ins=20080000", out_pc, out_instr);
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'h2008_0000 + 32'(k);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_jump();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage for the pipelined MIPS core, sitting between the instruction memory and decode. It owns the fetch PC and reads one word per cycle from a combinational-read instruction memory. Fetched instructions are buffered in a DEPTH-entry FIFO, tagged with their PC, and handed to decode through a valid/ready handshake. A single redirect input lets the back end flush the queue and restart fetch on branch/jump resolution.

## Interface
- DEPTH, 4: queue entries; power of two, >= 2
- IMEM_AW, 6: instruction-memory word-address width
- RESET_PC, 32'h0000_0000: fetch PC after reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_addr  out  IMEM_AW  word address = fetch_pc[IMEM_AW+1:2]
- imem_rd  in  32  instruction word read combinationally at imem_addr
- redirect  in  1  flush queue and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0)
- out_valid  out  1  head entry present (count != 0)
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  head instruction
- out_pc  out  32  head PC
- out_pcplus4  out  32  head PC + 4 (mod 2^32)
- out_jtaken  out  1  head was a predecoded J whose target was followed; constant 0 without macro
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- State: fetch_pc (32b), head/tail pointers ($clog2(DEPTH) bits, wrap mod DEPTH), count, DEPTH x {instr, pc, jtaken} storage.
- Reset values: fetch_pc=RESET_PC, head=tail=0, count=0; hence out_valid=0, out_jtaken=0, imem_addr=RESET_PC[IMEM_AW+1:2]; out_instr/out_pc/out_pcplus4 reflect entry 0 and are don't-care while out_valid=0.
- pop = out_valid & out_ready & !redirect.
- push = !redirect & (count < DEPTH | pop); a full queue accepts a push in the same cycle it pops.
- On push: storage[tail] <= {imem_rd, fetch_pc, jt}; tail++; fetch_pc <= next_pc. Without push fetch_pc holds (imem_addr stable under backpressure).
- next_pc = fetch_pc + 4 (mod 2^32), unless jump predecode applies (Configuration).
- count' = count + push - pop.
- Redirect (priority over everything): head <= 0, tail <= 0, count <= 0, fetch_pc <= {redirect_pc[31:2], 2'b00}; out_ready ignored, no push, no pop that cycle. Entry at head when redirect is high is discarded, not consumed.
- imem_addr uses only fetch_pc[IMEM_AW+1:2]; upper PC bits alias (wrap) silently.

## Timing
- Latency: instruction at PC X enters queue on edge after fetch_pc=X; out_valid rises in the following cycle.
- Reset release: first edge with reset=0 pushes RESET_PC; out_valid=1 from then on.
- Redirect at edge N: queue empty after N; push of redirect_pc at N+1; out_valid=1 after N+1 (one bubble cycle).
- Steady state with out_ready=1: one instruction per cycle, no bubbles, count stays 1.
- Reset asserted mid-operation clears state asynchronously regardless of clk; in-flight entries lost.
- Outputs are registered-state driven; only imem_addr→imem_rd is a combinational path through the block.

## Configuration
- FETCH_JUMP_PREDECODE_EN defined: on push, if imem_rd[31:26]==6'b000010 (J), next_pc = {fetch_pc_plus4[31:28], imem_rd[25:0], 2'b00} and stored jtaken=1; the J itself is still enqueued. Redirect still has priority.
- Undefined: next_pc always fetch_pc+4; jtaken stored as 0; out_jtaken tied 0; J resolution relies on redirect from the back end.

## Test plan
- Imem word k = 32'h2008_0000+k, out_ready=1 after reset -> out_pc 0,4,8,12,… on consecutive cycles, out_instr 2008_0000, 2008_0001, …, count=1.
- out_ready=0 for 10 cycles after reset -> count saturates at 4, imem_addr holds 4, out_pc stays 0; raise out_ready -> pcs 0,4,8,12,16 with no gap.
- Full queue, redirect=1 with redirect_pc=32'h0000_0023 and out_ready=1 -> count=0 next cycle, head not consumed, then out_pc=0x20, out_valid one cycle later.
- Word 2 = 32'h0800_0010 (j 0x40), macro on -> out_pc sequence 0,4,8,0x40,0x44; out_jtaken=1 only for pc 8; macro off -> 0,4,8,12, out_jtaken=0.
- Assert reset for half a cycle while count=3 -> count=0, out_valid=0 immediately; after release stream restarts at RESET_PC.
- fetch_pc=32'hFFFF_FFFC via redirect -> next entry pc wraps to 0x0000_0000, out_pcplus4 of first entry = 0.
